// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU datapath types
package cpu_types_pkg;

    localparam int WORD_W   = 32;
    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

endpackage

// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - register-file write port (writer drives, rf receives)
interface register_file_if;
    import cpu_types_pkg::*;

    logic     wen;
    regbits_t wsel;
    word_t    wdat;

    modport wb (output wen, output wsel, output wdat);
    modport rf (input wen, input wsel, input wdat);

endinterface

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - pending-write scoreboard with set/clear/flush
module wb_scoreboard
    import cpu_types_pkg::*;
(
    input  logic                clk,
    input  logic                n_rst,
    input  logic                set_en,
    input  regbits_t            set_sel,
    input  logic                clr_en,
    input  regbits_t            clr_sel,
    input  logic                flush,
    output logic [NUM_REGS-1:0] busy
);

    logic [NUM_REGS-1:0] busy_nxt;

    // Order matters: flush, then clear, then set, so a same-cycle issue always survives.
    always_comb begin
        busy_nxt = busy;
        if (flush)
            busy_nxt = '0;
        if (clr_en)
            busy_nxt[clr_sel] = 1'b0;
        if (set_en && (set_sel != '0))
            busy_nxt[set_sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!n_rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

endmodule

// File: rtl/register_writeback.sv
// rtl/register_writeback.sv - result writeback stage with scoreboard; optional WB_BYPASS_EN bypass
module register_writeback
    import cpu_types_pkg::*;
#(
    parameter bit ERR_STICKY = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                issue_en,
    input  regbits_t            issue_sel,
    input  regbits_t            rsel_1,
    input  regbits_t            rsel_2,
    input  logic                res_valid,
    input  regbits_t            res_sel,
    input  word_t               res_dat,
    input  logic                flush,
    register_file_if.wb         rf_wr,
    output logic                hazard,
    output logic                byp_1,
    output logic                byp_2,
    output logic [NUM_REGS-1:0] busy,
    output logic                err
);

    logic     wen_q;
    regbits_t wsel_q;
    word_t    wdat_q;
    logic     orphan;

    assign orphan = res_valid && (res_sel != '0) && !busy[res_sel];

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wen_q  <= 1'b0;
            wsel_q <= '0;
            wdat_q <= '0;
            err    <= 1'b0;
        end else begin
            wen_q  <= res_valid && (res_sel != '0);
            wsel_q <= res_sel;
            wdat_q <= res_dat;
            if (ERR_STICKY)
                err <= err | orphan;
            else
                err <= orphan;
        end
    end

    assign rf_wr.wen  = wen_q;
    assign rf_wr.wsel = wsel_q;
    assign rf_wr.wdat = wdat_q;

    wb_scoreboard u_scoreboard (
        .clk     (clk),
        .n_rst   (n_rst),
        .set_en  (issue_en),
        .set_sel (issue_sel),
        .clr_en  (wen_q),
        .clr_sel (wsel_q),
        .flush   (flush),
        .busy    (busy)
    );

`ifdef WB_BYPASS_EN
    assign byp_1 = wen_q && (wsel_q == rsel_1) && (rsel_1 != '0);
    assign byp_2 = wen_q && (wsel_q == rsel_2) && (rsel_2 != '0);
`else
    assign byp_1 = 1'b0;
    assign byp_2 = 1'b0;
`endif

    // A source served by the bypass is not a hazard even though its busy bit is still set.
    assign hazard = (busy[rsel_1] && (rsel_1 != '0) && !byp_1) ||
                    (busy[rsel_2] && (rsel_2 != '0) && !byp_2);

endmodule

// File: doc/register_writeback.md
REGISTER_WRITEBACK -- requirements
Module: register_writeback

Interface
REQ-001 Parameter ERR_STICKY, default 1, meaning: 1 = err holds until reset; 0 = err pulses for one cycle.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 n_rst  input  1  reset, synchronous, active-low.
REQ-004 issue_en  input  1  decode issues an instruction that writes a register.
REQ-005 issue_sel  input  5  destination register of the issued instruction.
REQ-006 rsel_1, rsel_2  input  5 each  source registers queried by decode.
REQ-007 res_valid  input  1  memory stage presents a result this cycle.
REQ-008 res_sel  input  5  destination register of the result.
REQ-009 res_dat  input  32 (word_t)  result data.
REQ-010 flush  input  1  squash all pending writes not yet presented on res_*.
REQ-011 wen  output  1  register-file write enable (drives register_file_if wen).
REQ-012 wsel  output  5  register-file write select.
REQ-013 wdat  output  32 (word_t)  register-file write data.
REQ-014 hazard  output  1  a source register queried by decode has a pending write.
REQ-015 byp_1, byp_2  output  1 each  source 1/2 is satisfied by the write on wdat this cycle.
REQ-016 busy  output  32  scoreboard; bit n = register n has a pending write.
REQ-017 err  output  1  a result arrived for a register that was not busy.

Function
REQ-018 The block SHALL register res_valid/res_sel/res_dat into wen/wsel/wdat with exactly 1 cycle of latency.
REQ-019 wen SHALL be 0 whenever the registered res_sel is 0; register 0 is never written.
REQ-020 issue_en with issue_sel != 0 SHALL set busy[issue_sel] at the next edge; issue_sel = 0 SHALL be ignored.
REQ-021 A cycle with wen = 1 SHALL clear busy[wsel] at the next edge.
REQ-022 A set and a clear of the same register in the same cycle: the set SHALL win (busy stays 1).
REQ-023 flush SHALL clear every busy bit at the next edge, except bits set by issue_en in that same cycle.
REQ-024 flush SHALL NOT suppress the write being registered from res_* in that cycle.
REQ-025 hazard SHALL be combinational: (busy[rsel_1] and rsel_1 != 0) or (busy[rsel_2] and rsel_2 != 0), subject to REQ-032.
REQ-026 res_valid with res_sel != 0 and busy[res_sel] = 0 SHALL assert err at the next edge.
REQ-027 With ERR_STICKY = 1, err SHALL remain 1 until reset; with ERR_STICKY = 0, err SHALL be high for one cycle per offending result.
REQ-028 The block SHALL accept back-to-back results every cycle without stall.

Reset
REQ-029 While n_rst = 0 at a rising edge, the block SHALL set wen = 0, wsel = 0, wdat = 0, busy = 0 and err = 0.
REQ-030 Reset SHALL override issue_en, res_valid and flush in the same cycle; a pending write is lost.
REQ-031 While busy = 0 and wen = 0 after reset, hazard, byp_1 and byp_2 SHALL be 0.

Configuration
REQ-032 With macro WB_BYPASS_EN defined, byp_k SHALL be 1 when wen = 1, wsel = rsel_k and rsel_k != 0. Hazard SHALL then exclude any source with byp_k = 1.
REQ-033 Without WB_BYPASS_EN, byp_1 and byp_2 SHALL be tied to 0, and hazard SHALL follow REQ-025 unmodified.

Structure
REQ-034 word_t and regbits_t (5-bit) SHALL come from cpu_types_pkg. No new package types are required.
REQ-035 The busy vector, with its set/clear/flush logic, SHALL be a sub-module named wb_scoreboard.
REQ-036 The write-port outputs SHALL connect to register_file_if, playing the writer role opposite the rf modport.

Verification
REQ-037 Reset, then issue_en = 1 and issue_sel = 5; next cycle rsel_1 = 5 -> busy = 0x00000020, hazard = 1.
REQ-038 Result with res_sel = 5 and res_dat = 0xDEADBEEF -> next cycle wen = 1, wsel = 5, wdat = 0xDEADBEEF; the cycle after, busy[5] = 0.
   - With WB_BYPASS_EN, during the wen cycle byp_1 = 1 and hazard = 0.
REQ-039 In one cycle, issue_sel = 7 and a commit of register 7 -> busy[7] stays 1.
REQ-040 Issue registers 3, 4 and 9, then flush -> busy = 0.
   - A result for register 3 then gives wen = 1 and err = 1, and err persists with ERR_STICKY = 1.
REQ-041 issue_sel = 0 plus a result with res_sel = 0 -> busy = 0, wen = 0, err = 0.
   - rsel_1 = 0 and rsel_2 = 0 -> hazard = 0.
REQ-042 Reset asserted while wen = 1 and busy = 0x00000FF0 -> next cycle all outputs are 0.
